// File: rtl/reg_file_mp_if.sv
// Bus bundle for the multi-port register file: clear/ready control plus
// packed read and write port groups. The master drives requests, the slave
// (the register file) returns ready and read data.
interface reg_file_mp_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 1
);
  logic                              clear;
  logic                              ready;
  logic [READ_PORTS-1:0]             read_en;
  logic [READ_PORTS*ADDR_WIDTH-1:0]  read_addr;
  logic [READ_PORTS*DATA_WIDTH-1:0]  read_data;
  logic [WRITE_PORTS-1:0]            write_en;
  logic [WRITE_PORTS*ADDR_WIDTH-1:0] write_addr;
  logic [WRITE_PORTS*DATA_WIDTH-1:0] write_data;

  modport master (
    output clear, read_en, read_addr, write_en, write_addr, write_data,
    input  ready, read_data
  );

  modport slave (
    input  clear, read_en, read_addr, write_en, write_addr, write_data,
    output ready, read_data
  );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port register file with same-cycle write forwarding (highest write
// port wins) and a one-entry-per-cycle zeroing sweep after reset or clear,
// so the storage array itself never needs a bulk reset.
module reg_file_mp #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 1,
  parameter int ZERO_REG    = 1
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_mp_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  // Unpacked views of the packed write ports
  logic [ADDR_WIDTH-1:0]   wr_addr [WRITE_PORTS];
  logic [DATA_WIDTH-1:0]   wr_data [WRITE_PORTS];
  logic                    wr_store [WRITE_PORTS];

  for (genvar gi = 0; gi < WRITE_PORTS; gi++) begin : g_wr
    assign wr_addr[gi]  = bus.write_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign wr_data[gi]  = bus.write_data[gi*DATA_WIDTH +: DATA_WIDTH];
    // Register 0 is never stored to when it is hardwired
    assign wr_store[gi] = bus.write_en[gi] &&
                          !((ZERO_REG != 0) && (wr_addr[gi] == '0));
  end

  // State register: sweep state and counter, asynchronously reset into CLEAR
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: advance the sweep, restart it on clear, leave READY on clear
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        if (bus.clear) begin
          cnt_d = '0;
        end else if (cnt_q == LAST_ADDR) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (bus.clear) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
    endcase
  end

  // Storage update: sweep zeroes one entry per edge; normal writes in ascending
  // port order so the higher port lands last. Left unreset on purpose.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem_q[cnt_q] <= '0;
    end else if (!bus.clear) begin
      for (int w = 0; w < WRITE_PORTS; w++) begin
        if (wr_store[w]) begin
          mem_q[wr_addr[w]] <= wr_data[w];
        end
      end
    end
  end

  // Output logic: ready flag
  always_comb begin
    bus.ready = (state_q == ST_READY);
  end

  for (genvar gi = 0; gi < READ_PORTS; gi++) begin : g_rd
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] lane;

    assign rd_addr = bus.read_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign bus.read_data[gi*DATA_WIDTH +: DATA_WIDTH] = lane;

    // Output logic: per-lane read with forwarding; zero while sweeping,
    // disabled, or reading the hardwired register
    always_comb begin
      lane = '0;
      if ((state_q == ST_READY) && bus.read_en[gi] &&
          !((ZERO_REG != 0) && (rd_addr == '0))) begin
        lane = mem_q[rd_addr];
        for (int w = 0; w < WRITE_PORTS; w++) begin
          if (bus.write_en[w] && (wr_addr[w] == rd_addr)) begin
            lane = wr_data[w];
          end
        end
      end
    end
  end

endmodule
